// File: rtl/switch_port_tx.sv
// Per-port transmitter: buffers host packets, drops bad destinations, and launches
// single-cycle pulses into a switch input port with a minimum idle gap between them.
//
// state  | meaning
// S_IDLE | may launch when enabled and a packet is queued
// S_HOLD | enforcing the idle gap after a launch (gap_cnt counts down)
module switch_port_tx #(
    parameter int ADDR_WIDTH    = 4,
    parameter int PAYLOAD_WIDTH = 8,
    parameter int PORT_ID       = 0,
    parameter int FIFO_DEPTH    = 4,
    parameter int GAP           = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     host_valid,
    output logic                     host_ready,
    input  logic [ADDR_WIDTH-1:0]    host_target,
    input  logic [PAYLOAD_WIDTH-1:0] host_data,
    input  logic                     enable,
    output logic                     tx_valid,
    output logic [ADDR_WIDTH-1:0]    tx_source,
    output logic [ADDR_WIDTH-1:0]    tx_target,
    output logic [PAYLOAD_WIDTH-1:0] tx_data,
    output logic [15:0]              sent_cnt,
    output logic [15:0]              drop_cnt,
    output logic                     busy
);
    localparam int PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W   = PTR_W + 1;
    localparam int ENTRY_W = ADDR_WIDTH + PAYLOAD_WIDTH;
    localparam logic [CNT_W-1:0]      FULL    = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0]      CNT_ONE = CNT_W'(1);
    localparam logic [ADDR_WIDTH-1:0] ONE     = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] SELF    = ONE << PORT_ID;
    localparam logic [3:0]            GAP_LD  = 4'(GAP);

    typedef enum logic {S_IDLE, S_HOLD} state_t;

    state_t     state, state_nxt;
    logic [3:0] gap_cnt, gap_cnt_nxt;

    logic [ENTRY_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr, rd_ptr;
    logic [CNT_W-1:0]   count;

    logic accept, target_ok, push, pop, launch;

    // Exactly one bit set, and not addressed back to our own port.
    assign target_ok = (host_target != '0) &&
                       ((host_target & (host_target - ONE)) == '0) &&
                       (host_target != SELF);

    assign host_ready = (count != FULL);
    assign accept     = host_valid && host_ready;
    assign busy       = (state != S_IDLE) || (count != '0) || tx_valid;

    // FSM: state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            gap_cnt <= 4'd0;
        end else begin
            state   <= state_nxt;
            gap_cnt <= gap_cnt_nxt;
        end
    end

    // FSM: next state
    always_comb begin
        state_nxt   = state;
        gap_cnt_nxt = gap_cnt;
        case (state)
            S_IDLE: begin
                if (launch && (GAP != 0)) begin
                    state_nxt   = S_HOLD;
                    gap_cnt_nxt = GAP_LD;
                end
            end
            S_HOLD: begin
                gap_cnt_nxt = gap_cnt - 4'd1;
                if (gap_cnt == 4'd1)
                    state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        launch = (state == S_IDLE) && enable && (count != '0);
        pop    = launch;
        push   = accept && target_ok;
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= {host_target, host_data};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    // Fields are forced to zero whenever no pulse is being launched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_valid  <= 1'b0;
            tx_source <= '0;
            tx_target <= '0;
            tx_data   <= '0;
        end else if (launch) begin
            tx_valid               <= 1'b1;
            tx_source              <= SELF;
            {tx_target, tx_data}   <= mem[rd_ptr];
        end else begin
            tx_valid  <= 1'b0;
            tx_source <= '0;
            tx_target <= '0;
            tx_data   <= '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sent_cnt <= 16'd0;
            drop_cnt <= 16'd0;
        end else begin
            if (launch && (sent_cnt != 16'hFFFF))
                sent_cnt <= sent_cnt + 16'd1;
            if (accept && !target_ok && (drop_cnt != 16'hFFFF))
                drop_cnt <= drop_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_switch_port_tx.sv
// Bench for switch_port_tx: two instances (GAP=2/PORT_ID=0 and GAP=0/PORT_ID=2)
// compared cycle by cycle against a queue-and-timestamp reference model.
module tb_switch_port_tx;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       hv[2];
    logic [3:0] ht[2];
    logic [7:0] hd[2];
    logic       en[2];
    logic       hr[2];
    logic       txv[2];
    logic [3:0] txs[2];
    logic [3:0] txt[2];
    logic [7:0] txd[2];
    logic [15:0] sc[2];
    logic [15:0] dc[2];
    logic       bz[2];

    int checks = 0;
    int errors = 0;

    // Reference model: circular packet list, last-launch timestamp, counters.
    logic [11:0] m_buf[2][4];
    int          m_rd[2];
    int          m_n[2];
    int          m_last[2];
    int          m_edge = 0;
    logic [16:0] m_tx[2];
    logic [15:0] m_sent[2];
    logic [15:0] m_drop[2];

    always #5 clk = ~clk;

    switch_port_tx #(.ADDR_WIDTH(4), .PAYLOAD_WIDTH(8), .PORT_ID(0), .FIFO_DEPTH(4), .GAP(2)) dut_g2 (
        .clk(clk), .rst_n(rst_n), .host_valid(hv[0]), .host_ready(hr[0]),
        .host_target(ht[0]), .host_data(hd[0]), .enable(en[0]), .tx_valid(txv[0]),
        .tx_source(txs[0]), .tx_target(txt[0]), .tx_data(txd[0]),
        .sent_cnt(sc[0]), .drop_cnt(dc[0]), .busy(bz[0]));

    switch_port_tx #(.ADDR_WIDTH(4), .PAYLOAD_WIDTH(8), .PORT_ID(2), .FIFO_DEPTH(4), .GAP(0)) dut_g0 (
        .clk(clk), .rst_n(rst_n), .host_valid(hv[1]), .host_ready(hr[1]),
        .host_target(ht[1]), .host_data(hd[1]), .enable(en[1]), .tx_valid(txv[1]),
        .tx_source(txs[1]), .tx_target(txt[1]), .tx_data(txd[1]),
        .sent_cnt(sc[1]), .drop_cnt(dc[1]), .busy(bz[1]));

    function automatic int gap_of(int i);
        return (i == 0) ? 2 : 0;
    endfunction

    function automatic int port_of(int i);
        return (i == 0) ? 0 : 2;
    endfunction

    function automatic logic [50:0] obs(int i);
        return {hr[i], bz[i], txv[i], txs[i], txt[i], txd[i], sc[i], dc[i]};
    endfunction

    function automatic logic [50:0] expd(int i);
        logic b;
        b = m_tx[i][16] || (m_n[i] > 0) || ((m_edge - 1 - m_last[i]) < gap_of(i));
        return {(m_n[i] != 4), b, m_tx[i], m_sent[i], m_drop[i]};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_rd[i] = 0; m_n[i] = 0; m_last[i] = -1000;
            m_tx[i] = '0; m_sent[i] = '0; m_drop[i] = '0;
        end
    endtask

    // Applies the rules for one rising edge using the inputs present just before it.
    task automatic model_step();
        for (int i = 0; i < 2; i++) begin
            logic [3:0] self;
            bit acc, lau, ok;
            self = 4'b0001 << port_of(i);
            acc  = hv[i] && (m_n[i] < 4);
            lau  = en[i] && (m_n[i] > 0) && ((m_edge - m_last[i]) >= gap_of(i) + 1);
            if (lau) begin
                m_tx[i] = {1'b1, self, m_buf[i][m_rd[i]]};
                m_rd[i] = (m_rd[i] + 1) % 4;
                m_n[i]--;
                if (m_sent[i] != 16'hFFFF) m_sent[i]++;
                m_last[i] = m_edge;
            end else begin
                m_tx[i] = '0;
            end
            if (acc) begin
                ok = ($countones(ht[i]) == 1) && (ht[i] != self);
                if (ok) begin
                    m_buf[i][(m_rd[i] + m_n[i]) % 4] = {ht[i], hd[i]};
                    m_n[i]++;
                end else if (m_drop[i] != 16'hFFFF) begin
                    m_drop[i]++;
                end
            end
        end
        m_edge++;
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        for (int i = 0; i < 2; i++) begin
            hv[i] = 1'b0; ht[i] = '0; hd[i] = '0; en[i] = 1'b0;
        end
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (obs(i) !== {1'b1, 50'd0}) begin
                errors++;
                $display("FAIL reset_hold inst%0d got %h exp %h", i, obs(i), {1'b1, 50'd0});
            end
        end
        rst_n = 1'b1;
        model_reset();
        tick();
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (obs(i) !== expd(i)) begin
                errors++;
                $display("FAIL reset_release inst%0d got %h exp %h", i, obs(i), expd(i));
            end
        end
    endtask

    task automatic test_single();
        en[0] = 1'b1; hv[0] = 1'b1; ht[0] = 4'b0100; hd[0] = 8'hA5;
        tick();
        hv[0] = 1'b0;
        checks++;
        if (txv[0] !== 1'b0) begin
            errors++;
            $display("FAIL single_e0 tx_valid got %b exp 0", txv[0]);
        end
        tick();
        checks++;
        if ({txv[0], txs[0], txt[0], txd[0], sc[0]} !== {1'b1, 4'b0001, 4'b0100, 8'hA5, 16'd1}) begin
            errors++;
            $display("FAIL single_pulse got v=%b s=%b t=%b d=%h sent=%0d exp v=1 s=0001 t=0100 d=a5 sent=1",
                     txv[0], txs[0], txt[0], txd[0], sc[0]);
        end
        for (int c = 0; c < 4; c++) begin
            tick();
            checks++;
            if (obs(0) !== expd(0)) begin
                errors++;
                $display("FAIL single_after cyc%0d got %h exp %h", c, obs(0), expd(0));
            end
        end
        en[0] = 1'b0;
    endtask

    task automatic test_fill_drain();
        int pulse_t[$];
        logic [7:0] pulse_d[$];
        en[0] = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            hv[0] = 1'b1; ht[0] = 4'b0010; hd[0] = 8'(k);
            tick();
            checks++;
            if (obs(0) !== expd(0)) begin
                errors++;
                $display("FAIL fill k%0d got %h exp %h", k, obs(0), expd(0));
            end
        end
        hv[0] = 1'b0;
        checks++;
        if (hr[0] !== 1'b0) begin
            errors++;
            $display("FAIL fill_full host_ready got %b exp 0", hr[0]);
        end
        en[0] = 1'b1;
        for (int c = 0; c < 14; c++) begin
            tick();
            if (txv[0] === 1'b1) begin
                pulse_t.push_back(c);
                pulse_d.push_back(txd[0]);
            end
            checks++;
            if (obs(0) !== expd(0)) begin
                errors++;
                $display("FAIL drain cyc%0d got %h exp %h", c, obs(0), expd(0));
            end
        end
        checks++;
        if (pulse_t.size() != 4) begin
            errors++;
            $display("FAIL drain_count got %0d exp 4", pulse_t.size());
        end else begin
            for (int k = 0; k < 4; k++) begin
                checks++;
                if (pulse_d[k] !== 8'(k + 1) || (k > 0 && pulse_t[k] - pulse_t[k-1] != 3)) begin
                    errors++;
                    $display("FAIL drain_order k%0d got data %h spacing %0d exp data %h spacing 3",
                             k, pulse_d[k], (k > 0) ? pulse_t[k] - pulse_t[k-1] : 3, 8'(k + 1));
                end
            end
        end
        checks++;
        if (hr[0] !== 1'b1) begin
            errors++;
            $display("FAIL drain_ready host_ready got %b exp 1", hr[0]);
        end
        en[0] = 1'b0;
    endtask

    task automatic test_drops();
        logic [3:0]  bad[3];
        logic [15:0] d0, s0;
        int pulses = 0;
        bad[0] = 4'b0001; bad[1] = 4'b0011; bad[2] = 4'b0000;
        d0 = dc[0]; s0 = sc[0];
        en[0] = 1'b1;
        for (int k = 0; k < 6; k++) begin
            hv[0] = (k < 3); ht[0] = bad[k % 3]; hd[0] = 8'hC0 + 8'(k);
            tick();
            if (txv[0] === 1'b1) pulses++;
            checks++;
            if (obs(0) !== expd(0)) begin
                errors++;
                $display("FAIL drops cyc%0d got %h exp %h", k, obs(0), expd(0));
            end
        end
        checks++;
        if (dc[0] !== d0 + 16'd3 || sc[0] !== s0 || pulses != 0) begin
            errors++;
            $display("FAIL drops_totals got drop=%0d sent=%0d pulses=%0d exp drop=%0d sent=%0d pulses=0",
                     dc[0], sc[0], pulses, d0 + 16'd3, s0);
        end
        idle_inputs();
    endtask

    task automatic test_back_to_back();
        logic [7:0] dseq[6];
        logic       vseq[6];
        en[1] = 1'b0;
        for (int k = 0; k < 3; k++) begin
            hv[1] = 1'b1; ht[1] = 4'b1000; hd[1] = 8'h10 + 8'(k);
            tick();
        end
        hv[1] = 1'b0;
        en[1] = 1'b1;
        for (int c = 0; c < 6; c++) begin
            tick();
            vseq[c] = txv[1];
            dseq[c] = txd[1];
            checks++;
            if (obs(1) !== expd(1)) begin
                errors++;
                $display("FAIL b2b cyc%0d got %h exp %h", c, obs(1), expd(1));
            end
        end
        for (int c = 0; c < 6; c++) begin
            checks++;
            if (vseq[c] !== (c < 3) || (c < 3 && dseq[c] !== 8'h10 + 8'(c))) begin
                errors++;
                $display("FAIL b2b_seq cyc%0d got v=%b d=%h exp v=%0d d=%h",
                         c, vseq[c], dseq[c], (c < 3), 8'h10 + 8'(c));
            end
        end
        idle_inputs();
    endtask

    task automatic test_mid_hold_reset();
        en[0] = 1'b0;
        for (int k = 0; k < 3; k++) begin
            hv[0] = 1'b1; ht[0] = 4'b0100; hd[0] = 8'h30 + 8'(k);
            tick();
        end
        hv[0] = 1'b0;
        en[0] = 1'b1;
        tick();
        checks++;
        if (obs(0) !== expd(0) || txv[0] !== 1'b1) begin
            errors++;
            $display("FAIL hold_launch got %h exp %h", obs(0), expd(0));
        end
        #2;
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (obs(i) !== {1'b1, 50'd0}) begin
                errors++;
                $display("FAIL async_reset inst%0d got %h exp %h", i, obs(i), {1'b1, 50'd0});
            end
        end
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int c = 0; c < 8; c++) begin
            tick();
            checks++;
            if (obs(0) !== expd(0)) begin
                errors++;
                $display("FAIL post_reset cyc%0d got %h exp %h", c, obs(0), expd(0));
            end
        end
        checks++;
        if ({txv[0], bz[0], sc[0], dc[0]} !== 34'd0) begin
            errors++;
            $display("FAIL post_reset_quiet got v=%b busy=%b sent=%0d drop=%0d exp all 0",
                     txv[0], bz[0], sc[0], dc[0]);
        end
        idle_inputs();
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < 2; i++) begin
                hv[i] = ($urandom_range(0, 9) < 6);
                if ($urandom_range(0, 4) == 0)
                    ht[i] = 4'($urandom_range(0, 15));
                else
                    ht[i] = 4'b0001 << $urandom_range(0, 3);
                hd[i] = 8'($urandom);
                en[i] = ($urandom_range(0, 9) < 7);
            end
            tick();
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (obs(i) !== expd(i)) begin
                    errors++;
                    $display("FAIL random inst%0d cyc%0d got %h exp %h", i, c, obs(i), expd(i));
                end
            end
        end
        idle_inputs();
        en[0] = 1'b1; en[1] = 1'b1;
        for (int c = 0; c < 20; c++) begin
            tick();
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (obs(i) !== expd(i)) begin
                    errors++;
                    $display("FAIL random_drain inst%0d cyc%0d got %h exp %h", i, c, obs(i), expd(i));
                end
            end
        end
        checks++;
        if (bz[0] !== 1'b0 || bz[1] !== 1'b0) begin
            errors++;
            $display("FAIL random_idle busy got %b%b exp 00", bz[0], bz[1]);
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        model_reset();
        test_reset();
        test_single();
        test_fill_drain();
        test_drops();
        test_back_to_back();
        test_mid_hold_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1);
    end

endmodule
